// File: rtl/dcache_pkg.sv
// Shared types and field geometry for the 2-way data cache controller.
package dcache_pkg;

    localparam int TAG_W      = 23;
    localparam int IDX_W      = 4;
    localparam int OFFSET_W   = 5;
    localparam int VALID_BIT  = 24;
    localparam int DIRTY_BIT  = 23;
    localparam int SRAM_TAG_W = 25;
    localparam int LINE_W     = 256;
    localparam int WORD_W     = 32;
    localparam int WSEL_W     = 3;

    typedef enum logic [2:0] {
        IDLE,
        MISS,
        WRITEBACK,
        READMISS,
        READMISSOK
    } state_e;

endpackage

// File: rtl/dcache_word_merge.sv
// Combinational 32-bit word select and word insert on a 256-bit cache line.
module dcache_word_merge
    import dcache_pkg::*;
(
    input  logic [LINE_W-1:0] line_i,
    input  logic [WSEL_W-1:0] word_sel_i,
    input  logic [WORD_W-1:0] word_i,
    output logic [WORD_W-1:0] word_o,
    output logic [LINE_W-1:0] line_o
);

    logic [7:0] bit_base;

    assign bit_base = {word_sel_i, 5'd0};
    assign word_o   = line_i[bit_base +: WORD_W];

    always_comb begin
        line_o = line_i;
        line_o[bit_base +: WORD_W] = word_i;
    end

endmodule

// File: rtl/dcache_controller.sv
// 2-way set-associative D-cache controller: same-cycle hits, write-back/fill on miss.
// Optional hit/miss counters are enabled with the DCACHE_STATS_EN macro.
module dcache_controller
    import dcache_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [31:0]           cpu_addr_i,
    input  logic [WORD_W-1:0]     cpu_data_i,
    input  logic                  cpu_MemRead_i,
    input  logic                  cpu_MemWrite_i,
    output logic [WORD_W-1:0]     cpu_data_o,
    output logic                  cpu_stall_o,
    output logic [31:0]           mem_addr_o,
    output logic [LINE_W-1:0]     mem_data_o,
    output logic                  mem_enable_o,
    output logic                  mem_write_o,
    input  logic [LINE_W-1:0]     mem_data_i,
    input  logic                  mem_ack_i,
    output logic [IDX_W-1:0]      cache_sram_index_o,
    output logic [SRAM_TAG_W-1:0] cache_sram_tag_o,
    output logic [LINE_W-1:0]     cache_sram_data_o,
    output logic                  cache_sram_enable_o,
    output logic                  cache_sram_write_o,
    input  logic [SRAM_TAG_W-1:0] cache_sram_tag_i,
    input  logic [LINE_W-1:0]     cache_sram_data_i,
    input  logic                  cache_sram_hit_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]           hit_cnt_o,
    output logic [31:0]           miss_cnt_o
`endif
);

    state_e state_q, state_d;

    logic              req;
    logic              is_store;
    logic [TAG_W-1:0]  cpu_tag;
    logic [IDX_W-1:0]  idx;
    logic [WSEL_W-1:0] word_sel;
    logic [WORD_W-1:0] rd_word;
    logic [LINE_W-1:0] merged_line;
    logic              unused_byte_bits;

    assign req              = cpu_MemRead_i | cpu_MemWrite_i;
    assign is_store         = cpu_MemWrite_i;
    assign cpu_tag          = cpu_addr_i[31:9];
    assign idx              = cpu_addr_i[8:5];
    assign word_sel         = cpu_addr_i[4:2];
    assign unused_byte_bits = ^cpu_addr_i[1:0];

    assign cache_sram_index_o  = idx;
    assign cache_sram_enable_o = req;

    dcache_word_merge u_merge (
        .line_i     (cache_sram_data_i),
        .word_sel_i (word_sel),
        .word_i     (cpu_data_i),
        .word_o     (rd_word),
        .line_o     (merged_line)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        cpu_stall_o        = 1'b0;
        cpu_data_o         = '0;
        mem_enable_o       = 1'b0;
        mem_write_o        = 1'b0;
        mem_addr_o         = '0;
        mem_data_o         = '0;
        cache_sram_write_o = 1'b0;
        cache_sram_tag_o   = {2'b00, cpu_tag};
        cache_sram_data_o  = cache_sram_data_i;

        case (state_q)
            IDLE: begin
                if (req) begin
                    if (cache_sram_hit_i) begin
                        if (is_store) begin
                            cache_sram_write_o = 1'b1;
                            cache_sram_tag_o   = {1'b1, 1'b1, cpu_tag};
                            cache_sram_data_o  = merged_line;
                        end else begin
                            cpu_data_o = rd_word;
                        end
                    end else begin
                        cpu_stall_o = 1'b1;
                        state_d     = MISS;
                    end
                end
            end
            MISS: begin
                cpu_stall_o = 1'b1;
                if (cache_sram_tag_i[VALID_BIT] && cache_sram_tag_i[DIRTY_BIT]) begin
                    state_d = WRITEBACK;
                end else begin
                    state_d = READMISS;
                end
            end
            WRITEBACK: begin
                cpu_stall_o  = 1'b1;
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {cache_sram_tag_i[TAG_W-1:0], idx, {OFFSET_W{1'b0}}};
                mem_data_o   = cache_sram_data_i;
                if (mem_ack_i) begin
                    state_d = READMISS;
                end
            end
            READMISS: begin
                cpu_stall_o  = 1'b1;
                mem_enable_o = 1'b1;
                mem_addr_o   = {cpu_tag, idx, {OFFSET_W{1'b0}}};
                // Fill lands in the SRAM in the ack cycle so the replay sees it.
                if (mem_ack_i) begin
                    cache_sram_write_o = 1'b1;
                    cache_sram_tag_o   = {1'b1, 1'b0, cpu_tag};
                    cache_sram_data_o  = mem_data_i;
                    state_d            = READMISSOK;
                end
            end
            READMISSOK: begin
                cpu_stall_o = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef DCACHE_STATS_EN
    logic        idle_hit;
    logic        miss_start;
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    assign idle_hit   = (state_q == IDLE) && req && cache_sram_hit_i;
    assign miss_start = (state_q == IDLE) && (state_d == MISS);
    assign hit_cnt_d  = hit_cnt_q + {31'd0, idle_hit};
    assign miss_cnt_d = miss_cnt_q + {31'd0, miss_start};

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller: hit vector table plus miss/write-back/reset sequences.
module tb_dcache_controller;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata;
    logic         cpu_rd, cpu_wr, cpu_stall;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata, mem_rdata;
    logic         mem_en, mem_we, mem_ack;
    logic [3:0]   sram_idx;
    logic [24:0]  sram_tag_o, sram_tag_i;
    logic [255:0] sram_data_o, sram_data_i;
    logic         sram_en, sram_we, sram_hit;
`ifdef DCACHE_STATS_EN
    logic [31:0]  hit_cnt, miss_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dcache_controller dut (
        .clk_i               (clk),
        .rst_n_i             (rst_n),
        .cpu_addr_i          (cpu_addr),
        .cpu_data_i          (cpu_wdata),
        .cpu_MemRead_i       (cpu_rd),
        .cpu_MemWrite_i      (cpu_wr),
        .cpu_data_o          (cpu_rdata),
        .cpu_stall_o         (cpu_stall),
        .mem_addr_o          (mem_addr),
        .mem_data_o          (mem_wdata),
        .mem_enable_o        (mem_en),
        .mem_write_o         (mem_we),
        .mem_data_i          (mem_rdata),
        .mem_ack_i           (mem_ack),
        .cache_sram_index_o  (sram_idx),
        .cache_sram_tag_o    (sram_tag_o),
        .cache_sram_data_o   (sram_data_o),
        .cache_sram_enable_o (sram_en),
        .cache_sram_write_o  (sram_we),
        .cache_sram_tag_i    (sram_tag_i),
        .cache_sram_data_i   (sram_data_i),
        .cache_sram_hit_i    (sram_hit)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt_o           (hit_cnt),
        .miss_cnt_o          (miss_cnt)
`endif
    );

    typedef struct {
        logic         rd;
        logic         wr;
        logic [31:0]  addr;
        logic [31:0]  wdata;
        logic         hit;
        logic [31:0]  base;
        logic [31:0]  exp_rdata;
        logic         exp_we;
        logic [3:0]   exp_idx;
        logic [24:0]  exp_tag;
        logic [255:0] exp_line;
    } vec_t;

    typedef struct {
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] data;
    } mem_exp_t;

    vec_t     vecs[8];
    vec_t     expq[$];
    mem_exp_t memq[$];

    function automatic logic [255:0] mkline_sub(input logic [31:0] base, input int sel,
                                                 input logic [31:0] data);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) begin
            l[w*32 +: 32] = (w == sel) ? data : base + 32'(w);
        end
        return l;
    endfunction

    function automatic logic [255:0] mkline(input logic [31:0] base);
        return mkline_sub(base, -1, 32'd0);
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push_mem(input logic wr, input logic [31:0] addr, input logic [255:0] data);
        mem_exp_t e;
        e.wr = wr;
        e.addr = addr;
        e.data = data;
        memq.push_back(e);
    endtask

    // Called just after a posedge; answers the next memory request after lat cycles.
    task automatic mem_serve(input int lat, input logic [255:0] fill, input logic [24:0] fill_tag);
        mem_exp_t e;
        bit found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (mem_en) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("mem_req_seen", found, 1'b1);
        if (!found || memq.size() == 0) return;
        e = memq.pop_front();
        chk("mem_write", mem_we, e.wr);
        chk("mem_addr", mem_addr, e.addr);
        if (e.wr) chk("mem_wb_data", mem_wdata, e.data);
        chk("mem_stall", cpu_stall, 1'b1);
        for (int k = 1; k < lat; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("mem_en_hold", mem_en, 1'b1);
            chk("mem_addr_hold", mem_addr, e.addr);
            chk("mem_write_hold", mem_we, e.wr);
        end
        @(posedge clk); #1;
        mem_ack = 1'b1;
        mem_rdata = fill;
        @(negedge clk);
        chk("mem_en_ack", mem_en, 1'b1);
        if (!e.wr) begin
            chk("fill_sram_we", sram_we, 1'b1);
            chk("fill_sram_tag", sram_tag_o, fill_tag);
            chk("fill_sram_data", sram_data_o, fill);
        end else begin
            chk("wb_no_sram_we", sram_we, 1'b0);
        end
        @(posedge clk); #1;
        mem_ack = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        logic [255:0] fillA, victim, fillB;

        //            rd    wr    addr          wdata         hit   base          rdata         we    idx   tag           line
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0404, 32'h0,        1'b1, 32'hA000_0000, 32'h0,        1'b0, 4'h0, 25'h0,       256'h0};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0404, 32'h0,        1'b1, 32'hA000_0000, 32'hA000_0001, 1'b0, 4'h0, 25'h0,       256'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_041C, 32'h0,        1'b1, 32'hA000_0000, 32'hA000_0007, 1'b0, 4'h0, 25'h0,       256'h0};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_0403, 32'h0,        1'b1, 32'hA000_0000, 32'hA000_0000, 1'b0, 4'h0, 25'h0,       256'h0};
        vecs[4] = '{1'b0, 1'b1, 32'h0000_0404, 32'hDEADBEEF, 1'b1, 32'hB000_0000, 32'h0,        1'b1, 4'h0, 25'h180_0002,
                    mkline_sub(32'hB000_0000, 1, 32'hDEADBEEF)};
        vecs[5] = '{1'b0, 1'b1, 32'h0000_01F8, 32'h1234_5678, 1'b1, 32'hC000_0000, 32'h0,        1'b1, 4'hF, 25'h180_0000,
                    mkline_sub(32'hC000_0000, 6, 32'h1234_5678)};
        vecs[6] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0BAD_F00D, 1'b1, 32'hD000_0000, 32'h0,        1'b1, 4'hF, 25'h1FF_FFFF,
                    mkline_sub(32'hD000_0000, 7, 32'h0BAD_F00D)};
        vecs[7] = '{1'b1, 1'b0, 32'h0000_04A8, 32'h0,        1'b1, 32'hE000_0000, 32'hE000_0002, 1'b0, 4'h5, 25'h0,       256'h0};

        rst_n = 1'b0;
        cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        sram_hit = 1'b0; sram_tag_i = '0; sram_data_i = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", cpu_stall, 1'b0);
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_cpu_data", cpu_rdata, 32'h0);
        chk("rst_sram_we", sram_we, 1'b0);
`ifdef DCACHE_STATS_EN
        chk("rst_hit_cnt", hit_cnt, 32'd0);
        chk("rst_miss_cnt", miss_cnt, 32'd0);
`endif

        // Cold load miss to 0x400, fill delayed 10 cycles, then replay hit
        fillA = mkline(32'h4000_0000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cpu_rd = 1'b1; cpu_addr = 32'h0000_0400;
        push_mem(1'b0, 32'h0000_0400, '0);
        @(negedge clk);
        chk("cold_stall_idle", cpu_stall, 1'b1);
        chk("cold_no_mem_idle", mem_en, 1'b0);
        chk("cold_cpu_data", cpu_rdata, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("cold_stall_miss", cpu_stall, 1'b1);
        chk("cold_no_mem_miss", mem_en, 1'b0);
        @(posedge clk); #1;
        mem_serve(10, fillA, 25'h100_0002);
        @(negedge clk);
        chk("cold_stall_rmok", cpu_stall, 1'b1);
        chk("cold_mem_drop", mem_en, 1'b0);
        @(posedge clk); #1;
        sram_hit = 1'b1; sram_data_i = fillA; sram_tag_i = 25'h100_0002;
        @(negedge clk);
        chk("replay_stall", cpu_stall, 1'b0);
        chk("replay_data", cpu_rdata, 32'h4000_0000);
        @(posedge clk); #1;
        @(negedge clk);
        @(posedge clk); #1;
        cpu_addr = 32'h0000_0408;
        @(negedge clk);
        chk("hit3_data", cpu_rdata, 32'h4000_0002);
        @(posedge clk); #1;
        cpu_rd = 1'b0;
        @(negedge clk);
`ifdef DCACHE_STATS_EN
        chk("stats_hit_cnt", hit_cnt, 32'd3);
        chk("stats_miss_cnt", miss_cnt, 32'd1);
`endif

        // Same-cycle hit vectors via scoreboard queue
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            cpu_rd = vecs[i].rd; cpu_wr = vecs[i].wr;
            cpu_addr = vecs[i].addr; cpu_wdata = vecs[i].wdata;
            sram_hit = vecs[i].hit; sram_data_i = mkline(vecs[i].base);
            sram_tag_i = {2'b10, vecs[i].addr[31:9]};
            expq.push_back(vecs[i]);
            @(negedge clk);
            v = expq.pop_front();
            chk($sformatf("v%0d_rdata", i), cpu_rdata, v.exp_rdata);
            chk($sformatf("v%0d_stall", i), cpu_stall, 1'b0);
            chk($sformatf("v%0d_sram_en", i), sram_en, v.rd | v.wr);
            chk($sformatf("v%0d_sram_we", i), sram_we, v.exp_we);
            chk($sformatf("v%0d_idx", i), sram_idx, v.exp_idx);
            chk($sformatf("v%0d_mem_en", i), mem_en, 1'b0);
            if (v.exp_we) begin
                chk($sformatf("v%0d_sram_tag", i), sram_tag_o, v.exp_tag);
                chk($sformatf("v%0d_sram_line", i), sram_data_o, v.exp_line);
            end
        end

        // Stray ack in IDLE is ignored
        @(posedge clk); #1;
        cpu_rd = 1'b0; cpu_wr = 1'b0; mem_ack = 1'b1;
        @(negedge clk);
        chk("stray_mem_en", mem_en, 1'b0);
        chk("stray_sram_we", sram_we, 1'b0);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        cpu_rd = 1'b1; cpu_addr = 32'h0000_0404; sram_hit = 1'b1; sram_data_i = fillA;
        @(negedge clk);
        chk("stray_after_stall", cpu_stall, 1'b0);
        chk("stray_after_data", cpu_rdata, 32'h4000_0001);

        // Dirty victim: store miss to 0x600 evicts dirty tag 1 line (0x200)
        victim = mkline(32'h5000_0000);
        fillB  = mkline(32'h6000_0000);
        @(posedge clk); #1;
        cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_addr = 32'h0000_0600; cpu_wdata = 32'hCAFE_F00D;
        sram_hit = 1'b0; sram_tag_i = 25'h180_0001; sram_data_i = victim;
        push_mem(1'b1, 32'h0000_0200, victim);
        push_mem(1'b0, 32'h0000_0600, '0);
        @(negedge clk);
        chk("dirty_stall_idle", cpu_stall, 1'b1);
        chk("dirty_no_sram_we", sram_we, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("dirty_stall_miss", cpu_stall, 1'b1);
        chk("dirty_no_mem_miss", mem_en, 1'b0);
        @(posedge clk); #1;
        mem_serve(3, '0, '0);
        mem_serve(2, fillB, 25'h100_0003);
        @(negedge clk);
        chk("dirty_stall_rmok", cpu_stall, 1'b1);
        chk("dirty_mem_drop", mem_en, 1'b0);
        @(posedge clk); #1;
        sram_hit = 1'b1; sram_data_i = fillB; sram_tag_i = 25'h100_0003;
        @(negedge clk);
        chk("dirty_replay_stall", cpu_stall, 1'b0);
        chk("dirty_replay_we", sram_we, 1'b1);
        chk("dirty_replay_tag", sram_tag_o, 25'h180_0003);
        chk("dirty_replay_line", sram_data_o, mkline_sub(32'h6000_0000, 0, 32'hCAFE_F00D));

        // Reset asserted during READMISS
        @(posedge clk); #1;
        cpu_wr = 1'b0; cpu_rd = 1'b1; cpu_addr = 32'h0000_0800;
        sram_hit = 1'b0; sram_tag_i = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstmid_readmiss_en", mem_en, 1'b1);
        chk("rstmid_readmiss_addr", mem_addr, 32'h0000_0800);
        @(posedge clk); #1;
        rst_n = 1'b0; cpu_rd = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstmid_mem_en", mem_en, 1'b0);
        chk("rstmid_stall", cpu_stall, 1'b0);
`ifdef DCACHE_STATS_EN
        chk("rstmid_hit_cnt", hit_cnt, 32'd0);
        chk("rstmid_miss_cnt", miss_cnt, 32'd0);
`endif
        @(posedge clk); #1;
        cpu_rd = 1'b1; sram_hit = 1'b1; sram_data_i = fillB;
        @(negedge clk);
        chk("rstmid_hit_stall", cpu_stall, 1'b0);
        chk("rstmid_hit_data", cpu_rdata, 32'h6000_0000);

        @(posedge clk); #1;
        cpu_rd = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
